// File: rtl/unsolved_token_fifo_if.sv
// Token handshake bundle between the BRAM copy stage, the unsolved-token FIFO and copytoken_selector.
interface unsolved_token_fifo_if #(
  parameter int unsigned WIDTH     = 33,
  parameter int unsigned DEPTH_LOG = 4
);
  logic                 wr_en;
  logic [WIDTH-1:0]     wr_data;
  logic                 rd_en;
  logic [WIDTH-1:0]     rd_data;
  logic                 valid_out;
  logic                 full;
  logic                 almost_full;
  logic [DEPTH_LOG:0]   count;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, valid_out, full, almost_full, count
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, valid_out, full, almost_full, count
  );
endinterface

// File: rtl/unsolved_token_fifo.sv
// First-word-fall-through queue replaying unresolved copy tokens to copytoken_selector.
// Optional statistics outputs are enabled by defining UNSOLVED_FIFO_STATS_EN.
module unsolved_token_fifo #(
  parameter int unsigned WIDTH     = 33,
  parameter int unsigned DEPTH_LOG = 4,
  parameter int unsigned AF_MARGIN = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  unsolved_token_fifo_if.slave bus
`ifdef UNSOLVED_FIFO_STATS_EN
  ,
  output logic                 overflow_sticky,
  output logic [15:0]          drop_cnt,
  output logic [DEPTH_LOG:0]   max_count
`endif
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] FULL_LEVEL = (DEPTH_LOG + 1)'(DEPTH);
  localparam logic [DEPTH_LOG:0] AF_LEVEL   =
    (AF_MARGIN >= DEPTH) ? '0 : (DEPTH_LOG + 1)'(DEPTH - AF_MARGIN);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr;
  logic [DEPTH_LOG-1:0] rd_ptr;
  logic [DEPTH_LOG:0]   cnt;
  logic [DEPTH_LOG:0]   cnt_next;
  logic                 is_full;
  logic                 mask_ok;
  logic                 pop;
  logic                 push;
  logic                 drop;

  assign is_full = (cnt == FULL_LEVEL);
  assign mask_ok = |bus.wr_data[23:16];
  assign pop     = bus.rd_en && (cnt != '0);
  // A pop frees the head slot this edge, so a full queue can still take a write.
  assign push    = bus.wr_en && mask_ok && (!is_full || pop);
  assign drop    = bus.wr_en && mask_ok && is_full && !pop;

  always_comb begin
    cnt_next = cnt;
    unique case ({push, pop})
      2'b10:   cnt_next = cnt + 1'b1;
      2'b01:   cnt_next = cnt - 1'b1;
      default: cnt_next = cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      cnt <= cnt_next;
    end
  end

  assign bus.rd_data     = mem[rd_ptr];
  assign bus.valid_out   = (cnt != '0);
  assign bus.full        = is_full;
  assign bus.almost_full = (cnt >= AF_LEVEL);
  assign bus.count       = cnt;

`ifdef UNSOLVED_FIFO_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_sticky <= 1'b0;
      drop_cnt        <= '0;
      max_count       <= '0;
    end else begin
      if (drop) begin
        overflow_sticky <= 1'b1;
        if (drop_cnt != '1) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
      end
      if (cnt_next > max_count) begin
        max_count <= cnt_next;
      end
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_unsolved_token_fifo.sv
// Scoreboard bench for unsolved_token_fifo: directed writes queue expected tokens, a monitor checks every pop.
module tb_unsolved_token_fifo;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [32:0] exp_q[$];

  unsolved_token_fifo_if #(.WIDTH(33), .DEPTH_LOG(4)) bus ();

`ifdef UNSOLVED_FIFO_STATS_EN
  logic        overflow_sticky;
  logic [15:0] drop_cnt;
  logic [4:0]  max_count;
`endif

  unsolved_token_fifo #(
    .WIDTH    (33),
    .DEPTH_LOG(4),
    .AF_MARGIN(4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus)
`ifdef UNSOLVED_FIFO_STATS_EN
    ,
    .overflow_sticky(overflow_sticky),
    .drop_cnt       (drop_cnt),
    .max_count      (max_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_tok(input logic [32:0] tok, input bit accepted);
    bus.wr_en   = 1'b1;
    bus.wr_data = tok;
    if (accepted) exp_q.push_back(tok);
    tick();
    bus.wr_en = 1'b0;
  endtask

  // Monitor: every cycle the selector pops, the head must match the oldest queued token.
  always @(negedge clk) begin
    if (rst_n && bus.rd_en && bus.valid_out) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", {31'd0, bus.rd_data}, 64'h1_0000_0000_0000);
      end else begin
        check("pop_data", {31'd0, bus.rd_data}, {31'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst_valid", bus.valid_out, 0);
    check("rst_count", bus.count, 0);
    check("rst_full", bus.full, 0);
    check("rst_af", bus.almost_full, 0);

    // rd_en on an empty queue is ignored
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check("empty_pop_count", bus.count, 0);
    check("empty_pop_valid", bus.valid_out, 0);

    // single token round trip
    write_tok(33'h0A5_FF_0012, 1'b1);
    check("single_valid", bus.valid_out, 1);
    check("single_data", bus.rd_data, 33'h0A5_FF_0012);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check("single_pop_valid", bus.valid_out, 0);
    check("single_pop_count", bus.count, 0);

    // fill to 16, flags track occupancy
    for (int i = 0; i < 16; i++) begin
      write_tok({9'h000, 8'h01, 16'(i)}, 1'b1);
      check("fill_count", bus.count, 64'(i + 1));
      check("fill_af", bus.almost_full, (i + 1 >= 12) ? 1 : 0);
      check("fill_full", bus.full, (i == 15) ? 1 : 0);
    end

    // 17th write with no pop is dropped
    write_tok({9'h000, 8'h01, 16'h0055}, 1'b0);
    check("ovf_count", bus.count, 16);
    check("ovf_full", bus.full, 1);
`ifdef UNSOLVED_FIFO_STATS_EN
    check("ovf_sticky", overflow_sticky, 1);
    check("ovf_drop_cnt", drop_cnt, 1);
    check("ovf_max_count", max_count, 16);
`endif

    // full with concurrent push and pop
    bus.rd_en = 1'b1;
    write_tok({9'h000, 8'h01, 16'h0100}, 1'b1);
    bus.rd_en = 1'b0;
    check("fullpp_count", bus.count, 16);
    check("fullpp_full", bus.full, 1);

    // drain: scoreboard expects offsets 1..15 then 0x0100
    bus.rd_en = 1'b1;
    repeat (16) tick();
    bus.rd_en = 1'b0;
    check("drain_count", bus.count, 0);
    check("drain_valid", bus.valid_out, 0);
    check("drain_af", bus.almost_full, 0);
    check("drain_sb_empty", exp_q.size(), 0);

    // zero byte-mask token is discarded
    write_tok({9'h1FF, 8'h00, 16'hBEEF}, 1'b0);
    check("zmask_valid", bus.valid_out, 0);
    check("zmask_count", bus.count, 0);
`ifdef UNSOLVED_FIFO_STATS_EN
    check("zmask_drop_cnt", drop_cnt, 1);
`endif

    // async reset with 7 entries held
    for (int i = 0; i < 7; i++) begin
      write_tok({9'h003, 8'h0F, 16'(16'h0200 + i)}, 1'b1);
    end
    check("pre_rst_count", bus.count, 7);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_count", bus.count, 0);
    check("async_rst_valid", bus.valid_out, 0);
    check("async_rst_full", bus.full, 0);
`ifdef UNSOLVED_FIFO_STATS_EN
    check("async_rst_sticky", overflow_sticky, 0);
    check("async_rst_drop_cnt", drop_cnt, 0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    write_tok(33'h155_80_7777, 1'b1);
    check("post_rst_valid", bus.valid_out, 1);
    check("post_rst_data", bus.rd_data, 33'h155_80_7777);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check("post_rst_count", bus.count, 0);
    check("final_sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: sim time %0t exceeded budget", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/unsolved_token_fifo.md
Name: unsolved_token_fifo

Overview:
- Buffers copy tokens that the downstream BRAM copy stage could not resolve because the source bytes were not yet written.
- Replays them to copytoken_selector through its unsolved_in, unsolved_valid_in and unsolved_rd_out port group.
- First-word-fall-through queue: the head entry is always presented; the selector pops it combinationally.
- Drives almost_full back to the BRAM stage so that stage stops producing unsolved tokens before any are lost.

Parameters:
- WIDTH, 33, token width: [32:24] address, [23:16] byte-valid mask, [15:0] offset.
- DEPTH_LOG, 4, log2 of the entry count (16 entries).
- AF_MARGIN, 4, almost_full asserts when free entries <= AF_MARGIN.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  unsolved token from the BRAM copy stage is valid this cycle.
- wr_data  in  WIDTH  returned token.
- rd_en  in  1  pop the head; driven by the selector's unsolved_rd_out.
- rd_data  out  WIDTH  head token; feeds the selector's unsolved_in.
- valid_out  out  1  FIFO not empty; feeds the selector's unsolved_valid_in.
- full  out  1  count == 2^DEPTH_LOG.
- almost_full  out  1  (2^DEPTH_LOG - count) <= AF_MARGIN.
- count  out  DEPTH_LOG+1  current occupancy.

Behaviour:
- Reset (async, rst_n low):
  - wr_ptr, rd_ptr and count go to 0.
  - valid_out=0, full=0, almost_full=0, count=0.
  - rd_data is don't-care while valid_out=0.
  - Reset asserted mid-operation discards all entries immediately; nothing is popped after release.
- Storage: 2^DEPTH_LOG x WIDTH array with DEPTH_LOG-bit pointers that wrap from 2^DEPTH_LOG-1 to 0. The array needs no reset.
- Read path:
  - rd_data = mem[rd_ptr], combinational.
  - valid_out = (count != 0), registered state only, no combinational path from wr_en.
- Write acceptance: a write is accepted when wr_en=1, wr_data[23:16] != 0, and (full=0 or a pop occurs this cycle).
- Pop: a pop occurs when rd_en=1 and valid_out=1. rd_en while empty is ignored.
- Zero byte-mask tokens (wr_data[23:16]==0) carry nothing to copy. They are silently discarded and never counted.
- Write latency: an accepted write is visible at rd_data/valid_out on the next clk edge. There is no same-cycle bypass, including when the FIFO is empty.
- Pop latency: rd_ptr advances on the clk edge of the pop. The selector captures rd_data in that same cycle.
- Occupancy update per edge:
  - Accept without pop: count+1.
  - Pop without accept: count-1.
  - Both, or neither: count unchanged.
- Full with simultaneous pop and write: the write is accepted, the pointers advance together, and count stays at 2^DEPTH_LOG.
- Full with write and no pop: the write is dropped and no state changes. This is an upstream protocol violation, since almost_full must have stopped the BRAM stage.
- full and almost_full are decoded from the registered count and are therefore registered-equivalent.
- The block uses no handshake with the selector's stop input. The selector already forces rd_en=0 while stopped.
- Token ordering is strictly FIFO. Token contents are never modified.

Optional Feature:
- Macro UNSOLVED_FIFO_STATS_EN.
- When defined, add three outputs:
  - overflow_sticky, 1 bit. Set on any dropped full-write, cleared only by reset.
  - drop_cnt, 16 bits. Counts dropped full-writes and saturates at 16'hFFFF. Zero-mask discards are not counted.
  - max_count, DEPTH_LOG+1 bits. High-water mark of count, updated on each edge, cleared by reset.
- When not defined, these ports and their logic are absent, and the write/pop behaviour above is identical.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles, then release. Required: valid_out=0, count=0, full=0, almost_full=0. Pulse rd_en with the FIFO empty: count stays 0.
- Single token: write 33'h0A5_FF_0012 at cycle t. Required: at t+1, valid_out=1 and rd_data=33'h0A5_FF_0012. Pop at t+1: at t+2, valid_out=0 and count=0.
- Fill and order:
  - Write 16 tokens with offset=i and bvalid=8'h01.
  - almost_full rises after the 12th write; full rises after the 16th.
  - A 17th write without pop is dropped (overflow_sticky=1, drop_cnt=1 when the feature is enabled).
  - Pops return offsets 0..15 in order.
- Full with concurrent push and pop: with 16 entries held, write offset 16'h0100 while popping the head. Required: count stays 16, full stays 1, and the last pop returns 16'h0100.
- Zero-mask discard: write a token with bvalid=8'h00 when empty. Required: valid_out stays 0 and count stays 0.
- Async reset mid-stream: with 7 entries held, drop rst_n between clock edges. Required: count=0 and valid_out=0 immediately. After release, a new write is read back first.
